// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO register unit: op codes, FSM states
// and the default datapath width.
package hilo_divider_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_MTHI   = 3'd1,
    OP_MTLO   = 3'd2,
    OP_MUL_WR = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIXUP  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One iteration of a restoring divider: shift {rem,quo} left by one and
// trial-subtract the divisor from the widened partial remainder.
module hilo_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] remShifted;
  logic [WIDTH:0] trialDiff;

  // The shifted remainder needs WIDTH+1 bits; its top bit is only set when the
  // subtraction is guaranteed to succeed, so truncating the result is safe.
  always_comb begin
    remShifted = {rem_i, quo_i[WIDTH-1]};
    trialDiff  = remShifted - {1'b0, divisor_i};
    if (!trialDiff[WIDTH]) begin
      rem_o = trialDiff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = remShifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Architectural HI/LO register pair with MTHI/MTLO/multiply capture and an
// iterative 1-bit-per-cycle DIV/DIVU unit that stalls the pipeline via busy.
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       op_i,
  input  logic             op_valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] alu_lo_i,
  input  logic [WIDTH-1:0] alu_hi_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic             signedOp;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  hilo_divider_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quo_o     (stepQuo)
  );

  // Operand magnitudes: DIV works on absolute values, DIVU on raw bits.
  always_comb begin
    signedOp = (op_i == OP_DIV);
    absA     = (signedOp && a_i[WIDTH-1]) ? -a_i : a_i;
    absB     = (signedOp && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // Next-state and datapath updates; ops are only accepted while idle.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid_i) begin
          case (op_i)
            OP_MTHI: hi_d = a_i;
            OP_MTLO: lo_d = a_i;
            OP_MUL_WR: begin
              hi_d = alu_hi_i;
              lo_d = alu_lo_i;
            end
            OP_DIV, OP_DIVU: begin
              negQuo_d  = signedOp && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              negRem_d  = signedOp && a_i[WIDTH-1];
              rem_d     = '0;
              quo_d     = absA;
              divisor_d = absB;
              cnt_d     = CNT_W'(WIDTH - 1);
              if (b_i == '0) begin
                // Divide by zero: preload the architected result and skip
                // straight to the commit cycle without any sign fix-up.
                quo_d    = '1;
                rem_d    = a_i;
                negQuo_d = 1'b0;
                negRem_d = 1'b0;
                state_d  = ST_FIXUP;
              end else begin
                state_d  = ST_DIVIDE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_DIVIDE: begin
        rem_d = stepRem;
        quo_d = stepQuo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        lo_d    = negQuo_q ? -quo_q : quo_q;
        hi_d    = negRem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and register update; reset aborts any divide without a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      negQuo_q  <= negQuo_d;
      negRem_q  <= negRem_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider.
module tb_hilo_divider;
  import hilo_divider_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rstN;
  logic [2:0]   op;
  logic         opValid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] aluLo;
  logic [W-1:0] aluHi;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int assertCount = 0;
  int failCount   = 0;

  hilo_divider #(
    .WIDTH(W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .op_i       (op),
    .op_valid_i (opValid),
    .a_i        (a),
    .b_i        (b),
    .alu_lo_i   (aluLo),
    .alu_hi_i   (aluHi),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Present one op for exactly one clock edge, returning 1 ns after that edge
  task automatic applyStimulus(input logic [2:0] opIn, input logic [W-1:0] aIn,
                               input logic [W-1:0] bIn, input logic [W-1:0] hiIn,
                               input logic [W-1:0] loIn);
    op      = opIn;
    a       = aIn;
    b       = bIn;
    aluHi   = hiIn;
    aluLo   = loIn;
    opValid = 1'b1;
    @(posedge clk);
    #1;
    opValid = 1'b0;
    op      = OP_NOP;
  endtask

  // Count cycles with busy high, bounded; returns at the first idle cycle
  task automatic waitIdle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; opValid = 1'b0; op = OP_NOP;
    a = '0; b = '0; aluLo = '0; aluHi = '0;
    #12;
    assertCount++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mthi_mtlo();
    applyStimulus(OP_MTHI, 32'h55AA55AA, 32'h0, 32'h0, 32'h0);
    assertCount++;
    if (hi !== 32'h55AA55AA || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mthi: hi=%h busy=%b, required hi=55aa55aa busy=0", hi, busy);
    end
    applyStimulus(OP_MTLO, 32'h1, 32'h0, 32'h0, 32'h0);
    assertCount++;
    if (hi !== 32'h55AA55AA || lo !== 32'h1 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mtlo: hi=%h lo=%h busy=%b, required 55aa55aa/1/0", hi, lo, busy);
    end
  endtask

  task automatic test_divu_basic();
    int cyc;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (cyc !== 33) begin
      failCount++;
      $display("[TB] FAIL divu_latency: busy cycles=%0d, required 33", cyc);
    end
    assertCount++;
    if (done !== 1'b1 || lo !== 32'd14 || hi !== 32'd2) begin
      failCount++;
      $display("[TB] FAIL divu_result: done=%b lo=%0d hi=%0d, required done=1 lo=14 hi=2", done, lo, hi);
    end
    @(posedge clk);
    #1;
    assertCount++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_div_signed();
    int cyc;
    applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      failCount++;
      $display("[TB] FAIL div_neg_dividend: lo=%h hi=%h, required fffffffd/ffffffff", lo, hi);
    end
    applyStimulus(OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'h1) begin
      failCount++;
      $display("[TB] FAIL div_neg_divisor: lo=%h hi=%h, required fffffffd/00000001", lo, hi);
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    applyStimulus(OP_DIVU, 32'h12345678, 32'h0, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (cyc !== 1 || done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL divzero_latency: busy cycles=%0d done=%b, required 1/1", cyc, done);
    end
    assertCount++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h12345678) begin
      failCount++;
      $display("[TB] FAIL divu_zero: lo=%h hi=%h, required ffffffff/12345678", lo, hi);
    end
    applyStimulus(OP_DIV, 32'h80000001, 32'h0, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (lo !== 32'hFFFFFFFF || hi !== 32'h80000001) begin
      failCount++;
      $display("[TB] FAIL div_zero_signed: lo=%h hi=%h, required ffffffff/80000001", lo, hi);
    end
  endtask

  task automatic test_overflow_and_ignore();
    int cyc;
    applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(OP_MUL_WR, 32'h0, 32'h0, 32'hA, 32'hB);
    assertCount++;
    if (hi !== 32'h80000001 || lo !== 32'hFFFFFFFF || busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ignore_while_busy: hi=%h lo=%h busy=%b, required 80000001/ffffffff/1", hi, lo, busy);
    end
    waitIdle(cyc);
    assertCount++;
    if (done !== 1'b1 || lo !== 32'h80000000 || hi !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL div_overflow: done=%b lo=%h hi=%h, required 1/80000000/0", done, lo, hi);
    end
    applyStimulus(OP_MUL_WR, 32'h0, 32'h0, 32'hA, 32'hB);
    assertCount++;
    if (hi !== 32'hA || lo !== 32'hB || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mul_wr_in_done: hi=%h lo=%h busy=%b, required a/b/0", hi, lo, busy);
    end
    applyStimulus(OP_DIVU, 32'h0, 32'd5, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (lo !== 32'h0 || hi !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL zero_dividend: lo=%h hi=%h, required 0/0", lo, hi);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
    end
    rstN = 1'b0;
    #1;
    assertCount++;
    if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_abort: hi=%h lo=%h busy=%b done=%b, required all zero", hi, lo, busy, done);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 32'h0, 32'h0);
    waitIdle(cyc);
    assertCount++;
    if (cyc !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL after_reset_divu: cycles=%0d lo=%0d hi=%0d, required 33/3/0", cyc, lo, hi);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    applyStimulus(OP_DIVU, 32'd1000, 32'd33, 32'h0, 32'h0);
    waitIdle(cyc);
    applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0);
    assertCount++;
    if (busy !== 1'b1 || lo !== 32'd30 || hi !== 32'd10) begin
      failCount++;
      $display("[TB] FAIL back_to_back_accept: busy=%b lo=%0d hi=%0d, required 1/30/10", busy, lo, hi);
    end
    waitIdle(cyc);
    assertCount++;
    if (lo !== 32'h0FFFFFFF || hi !== 32'hF) begin
      failCount++;
      $display("[TB] FAIL back_to_back_result: lo=%h hi=%h, required 0fffffff/0000000f", lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_overflow_and_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
